// File: rtl/slice_column_renderer_if.sv
// Purpose : bundle of the renderer's frame-control, slice-calc handshake and pixel-bus signals.
// Latency : n/a (wires only).
// Backpressure: none; the pixel bus is push-only, one pixel per cycle while plot is high.
//
// Signals
//   start_frame   frame request pulse (into renderer)
//   end_calc      slice calculation complete, level (into renderer)
//   slice_size    projected wall height, valid with end_calc (into renderer)
//   begin_calc    one-cycle slice calculation request (out of renderer)
//   column_count  current column index (out of renderer)
//   x, y, colour  pixel coordinate and colour (out of renderer)
//   plot          pixel write enable (out of renderer)
//   busy          frame in progress (out of renderer)
//   frame_done    one-cycle pulse after the last pixel of the frame (out of renderer)
// Modports: slave = renderer side, master = frame controller / slice calculator side.

interface slice_column_renderer_if;
    logic       start_frame;
    logic       end_calc;
    logic [6:0] slice_size;
    logic       begin_calc;
    logic [7:0] column_count;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       frame_done;

    modport master (
        output start_frame,
        output end_calc,
        output slice_size,
        input  begin_calc,
        input  column_count,
        input  x,
        input  y,
        input  colour,
        input  plot,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  start_frame,
        input  end_calc,
        input  slice_size,
        output begin_calc,
        output column_count,
        output x,
        output y,
        output colour,
        output plot,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/slice_column_renderer.sv
// Purpose : per-column frame sequencer; requests a slice height, then plots that column's pixels.
// Latency : per column 1 (request) + wait + 1 (latch) + draw cycles + 1 (next column).
// Backpressure: none on the pixel bus; waits on end_calc, forcing height 0 after CALC_TIMEOUT cycles.
//
// Ports
//   clock, resetn      rising-edge clock, asynchronous active-low reset
//   bus (slave)        start_frame / end_calc / slice_size in;
//                      begin_calc / column_count / x / y / colour / plot / busy / frame_done out
// Optional feature: define BACKGROUND_FILL_EN to sweep the whole column, painting ceiling above
// and floor below the wall. Without it only the wall rows are plotted and empty columns are skipped.

module slice_column_renderer #(
    parameter int         NUM_COLS     = 160,
    parameter int         SCREEN_H     = 120,
    parameter int         CALC_TIMEOUT = 1023,
    parameter logic [2:0] WALL_COL     = 3'b111
`ifdef BACKGROUND_FILL_EN
   ,parameter logic [2:0] CEIL_COL     = 3'b001,
    parameter logic [2:0] FLOOR_COL    = 3'b010
`endif
) (
    input  logic                   clock,
    input  logic                   resetn,
    slice_column_renderer_if.slave bus
);

    localparam int               TMO_W    = $clog2(CALC_TIMEOUT + 1);
    // The counter is compared before it increments, so matching CALC_TIMEOUT-1 ends the
    // CALC_TIMEOUT-th wait cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CALC_TIMEOUT - 1);
    localparam logic [7:0]       LAST_COL = 8'(NUM_COLS - 1);
    localparam logic [7:0]       ROWS     = 8'(SCREEN_H);
`ifdef BACKGROUND_FILL_EN
    localparam logic [6:0]       LAST_ROW = 7'(SCREEN_H - 1);
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CALC_REQ  = 3'd1,
        CALC_WAIT = 3'd2,
        LATCH     = 3'd3,
        DRAW      = 3'd4,
        NEXT_COL  = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [7:0]       column_q;
    logic             busy_q;
    logic             armed_q;      // end_calc has been seen low since this column's request
    logic [TMO_W-1:0] tmo_q;
    logic [6:0]       h_q;          // raw slice height for the current column
    logic [7:0]       bot_q;        // first row below the wall (exclusive bound)
`ifdef BACKGROUND_FILL_EN
    logic [7:0]       top_q;        // first wall row
`endif
    logic [6:0]       y_q;

    logic [7:0]       hc;
    logic [7:0]       top_calc;
    logic [7:0]       bot_calc;
    logic             calc_done;
    logic             calc_tmo;
    logic             last_pixel;

    // Wall extent: clamp to the screen, then centre. All operands are 8-bit and hc <= ROWS,
    // so neither the subtraction nor the addition can wrap.
    always_comb begin
        hc = {1'b0, h_q};
        if (hc > ROWS) begin
            hc = ROWS;
        end
        top_calc = (ROWS - hc) >> 1;
        bot_calc = top_calc + hc;
    end

    // A level left high by the previous column must not count as completion, hence armed_q.
    assign calc_done = armed_q && bus.end_calc;
    assign calc_tmo  = (tmo_q == TMO_LAST);

`ifdef BACKGROUND_FILL_EN
    assign last_pixel = (y_q == LAST_ROW);
`else
    // DRAW is only entered with hc >= 1, so bot_q >= 1 here.
    assign last_pixel = ({1'b0, y_q} == (bot_q - 8'd1));
`endif

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start_frame) begin
                    state_d = CALC_REQ;
                end
            end
            CALC_REQ: begin
                state_d = CALC_WAIT;
            end
            CALC_WAIT: begin
                if (calc_done || calc_tmo) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
`ifdef BACKGROUND_FILL_EN
                state_d = DRAW;
`else
                state_d = (hc == 8'd0) ? NEXT_COL : DRAW;
`endif
            end
            DRAW: begin
                if (last_pixel) begin
                    state_d = NEXT_COL;
                end
            end
            NEXT_COL: begin
                state_d = (column_q == LAST_COL) ? DONE : CALC_REQ;
            end
            DONE: begin
                // start_frame arriving here is deliberately dropped.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            column_q <= 8'd0;
            busy_q   <= 1'b0;
            armed_q  <= 1'b0;
            tmo_q    <= '0;
            h_q      <= 7'd0;
            bot_q    <= 8'd0;
`ifdef BACKGROUND_FILL_EN
            top_q    <= 8'd0;
`endif
            y_q      <= 7'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_frame) begin
                        column_q <= 8'd0;
                        busy_q   <= 1'b1;
                    end
                end
                CALC_REQ: begin
                    armed_q <= 1'b0;
                    tmo_q   <= '0;
                end
                CALC_WAIT: begin
                    if (!bus.end_calc) begin
                        armed_q <= 1'b1;
                    end
                    tmo_q <= tmo_q + 1'b1;
                    // Completion wins over a timeout landing in the same cycle.
                    if (calc_done) begin
                        h_q <= bus.slice_size;
                    end else if (calc_tmo) begin
                        h_q <= 7'd0;
                    end
                end
                LATCH: begin
                    bot_q <= bot_calc;
`ifdef BACKGROUND_FILL_EN
                    top_q <= top_calc;
                    y_q   <= 7'd0;
`else
                    y_q   <= top_calc[6:0];
`endif
                end
                DRAW: begin
                    if (!last_pixel) begin
                        y_q <= y_q + 7'd1;
                    end
                end
                NEXT_COL: begin
                    if (column_q != LAST_COL) begin
                        column_q <= column_q + 8'd1;
                    end
                end
                DONE: begin
                    busy_q   <= 1'b0;
                    column_q <= 8'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus.begin_calc   = (state_q == CALC_REQ);
        bus.plot         = (state_q == DRAW);
        bus.frame_done   = (state_q == DONE);
        bus.busy         = busy_q;
        bus.column_count = column_q;
        bus.x            = column_q;
        bus.y            = y_q;
        bus.colour       = 3'b000;
        if (state_q == DRAW) begin
`ifdef BACKGROUND_FILL_EN
            if ({1'b0, y_q} < top_q) begin
                bus.colour = CEIL_COL;
            end else if ({1'b0, y_q} < bot_q) begin
                bus.colour = WALL_COL;
            end else begin
                bus.colour = FLOOR_COL;
            end
`else
            bus.colour = WALL_COL;
`endif
        end
    end

endmodule

// File: tb/tb_slice_column_renderer.sv
`timescale 1ns/1ps

module tb_slice_column_renderer;

    localparam logic [2:0] WALL  = 3'b111;
    localparam logic [2:0] CEIL  = 3'b001;
    localparam logic [2:0] FLOOR = 3'b010;
    localparam int         COL_BUDGET = 2000;

    logic clock;
    logic resetn;
    int   n_checks;
    int   n_fail;

    slice_column_renderer_if bus ();

    slice_column_renderer dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame_pulse();
        @(negedge clock);
        bus.start_frame = 1'b1;
        @(negedge clock);
        bus.start_frame = 1'b0;
        check("start_begin_calc", {31'd0, bus.begin_calc}, 32'd1);
        check("start_busy", {31'd0, bus.busy}, 32'd1);
    endtask

    // Called at the negedge where begin_calc for column col is visible (cycle 0).
    // end_calc drops at cycle low_at and rises with slice_size at cycle high_at
    // (high_at < 0: never rises, the column must time out).
    // Returns at the negedge showing the next begin_calc or frame_done, or after
    // abort_plots pixels if abort_plots > 0.
    task automatic run_column(input int col, input int size_drv, input int size_exp,
                              input int low_at, input int high_at, input int abort_plots,
                              output bit ok, output bit saw_done);
        int hc, top, bot, draw, ystart, wait_c, cyc, nplots, bad, yy;
        logic [2:0] ecol;
        bit fin;
        hc     = (size_exp > 120) ? 120 : size_exp;
        top    = (120 - hc) / 2;
        bot    = top + hc;
`ifdef BACKGROUND_FILL_EN
        draw   = 120;
        ystart = 0;
`else
        draw   = hc;
        ystart = top;
`endif
        wait_c = (high_at < 0) ? 1023 : high_at;
        check($sformatf("col%0d_index", col), {24'd0, bus.column_count}, col);
        check($sformatf("col%0d_busy", col), {31'd0, bus.busy}, 32'd1);
        bus.slice_size = 7'd99;   // stale value that must never be latched
        cyc = 0; nplots = 0; bad = 0; fin = 1'b0; ok = 1'b0; saw_done = 1'b0;
        while (!fin) begin
            @(negedge clock);
            cyc++;
            bus.start_frame = 1'b0;
            if (bus.plot) begin
                yy   = ystart + nplots;
                ecol = (yy < top) ? CEIL : ((yy < bot) ? WALL : FLOOR);
                if (cyc != wait_c + 2 + nplots || bus.x != col[7:0] ||
                    bus.y != yy[6:0] || bus.colour !== ecol) begin
                    bad++;
                end
                nplots++;
                if (abort_plots > 0 && nplots == abort_plots) begin
                    check($sformatf("col%0d_pixels_before_abort", col), bad, 0);
                    ok = 1'b1;
                    return;
                end
            end
            if (bus.begin_calc || bus.frame_done) begin
                fin      = 1'b1;
                ok       = 1'b1;
                saw_done = bus.frame_done;
            end else if (cyc > COL_BUDGET) begin
                fin = 1'b1;
            end
            if (cyc == low_at) begin
                bus.end_calc = 1'b0;
            end
            if (high_at >= 0 && cyc == high_at) begin
                bus.end_calc   = 1'b1;
                bus.slice_size = 7'(size_drv);
            end
        end
        check($sformatf("col%0d_period", col), cyc, wait_c + draw + 3);
        check($sformatf("col%0d_plots", col), nplots, draw);
        check($sformatf("col%0d_bad_pixels", col), bad, 0);
    endtask

    initial begin
        bit ok;
        bit done;
        n_checks = 0;
        n_fail   = 0;
        resetn          = 1'b1;
        bus.start_frame = 1'b0;
        bus.end_calc    = 1'b0;
        bus.slice_size  = 7'd0;

        // ---- reset state
        #2 resetn = 1'b0;
        #1;
        check("rst_plot", {31'd0, bus.plot}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_begin_calc", {31'd0, bus.begin_calc}, 32'd0);
        check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        check("rst_column", {24'd0, bus.column_count}, 32'd0);
        check("rst_x", {24'd0, bus.x}, 32'd0);
        check("rst_y", {25'd0, bus.y}, 32'd0);
        check("rst_colour", {29'd0, bus.colour}, 32'd0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_begin_calc", {31'd0, bus.begin_calc}, 32'd0);

        // ---- frame A: full frame with directed per-column corner cases
        start_frame_pulse();
        for (int col = 0; col < 160; col++) begin
            int drv, expsz, lo, hi;
            drv = 40; expsz = 40; lo = 1; hi = 2;
            case (col)
                1: begin drv = 127; expsz = 127; end         // clamps to full height
                2: begin drv = 41; expsz = 41; bus.start_frame = 1'b1; end  // odd gap, restart ignored
                3: begin drv = 0; expsz = 0; end             // empty column
                4: begin drv = 20; expsz = 20; lo = 2; hi = 12; end  // stale high level first
                5: begin drv = 0; expsz = 0; hi = -1; end    // calculator never answers
                6: begin drv = 120; expsz = 120; end         // exactly screen height
                7: begin drv = 1; expsz = 1; end
                8: begin drv = 119; expsz = 119; end
                default: begin end
            endcase
            run_column(col, drv, expsz, lo, hi, 0, ok, done);
            if (!ok) break;
            if (col < 159) begin
                check($sformatf("col%0d_no_early_done", col), {31'd0, done}, 32'd0);
                if (done) break;
            end else begin
                check("frame_done_after_last", {31'd0, done}, 32'd1);
            end
        end
        // start_frame presented in the DONE cycle must be dropped
        bus.start_frame = 1'b1;
        @(negedge clock);
        bus.start_frame = 1'b0;
        check("post_done_busy", {31'd0, bus.busy}, 32'd0);
        check("post_done_pulse_width", {31'd0, bus.frame_done}, 32'd0);
        check("post_done_column", {24'd0, bus.column_count}, 32'd0);
        check("post_done_no_restart", {31'd0, bus.begin_calc}, 32'd0);
        @(negedge clock);
        check("post_done_still_idle", {31'd0, bus.busy}, 32'd0);

        // ---- frame B: reset in the middle of drawing column 57
        start_frame_pulse();
        ok = 1'b1;
        for (int col = 0; col < 57; col++) begin
            run_column(col, 10, 10, 1, 2, 0, ok, done);
            if (!ok || done) break;
        end
        run_column(57, 30, 30, 1, 2, 5, ok, done);
        resetn = 1'b0;
        #1;
        check("midrst_plot", {31'd0, bus.plot}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_begin_calc", {31'd0, bus.begin_calc}, 32'd0);
        check("midrst_column", {24'd0, bus.column_count}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("midrst_no_frame_done", {31'd0, bus.frame_done}, 32'd0);
            check("midrst_idle", {31'd0, bus.busy}, 32'd0);
        end
        start_frame_pulse();
        run_column(0, 60, 60, 1, 2, 0, ok, done);
        if (ok && !done) begin
            run_column(1, 7, 7, 1, 3, 0, ok, done);
        end
        resetn = 1'b0;
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
